pool_layer_param: RTL
=====================

# pool_layer_param

Parametrised, multi-channel, streaming successor to the pooling layer. Reads a stack of square feature maps word-by-word from layer memory and applies non-overlapping k×k pooling, selectable max or average. Writes each pooled word to a separate output region. Sits between the conv layer output buffer and the next layer's input region, driven by the layer sequencer via a start/done handshake.

## Interface
Parameters:
- DATA_W, 16, signed pixel width
- ADDR_W, 16, memory address width
- SIZE_W, 8, width of imgSize / imgsNumber fields
- MAX_WIN, 4, largest legal window; legal windows are 1, 2, 4 (powers of two ≤ MAX_WIN)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle job request, sampled only in IDLE
- mode  in  1  0 = max, 1 = average
- imgsNumber  in  SIZE_W  channel count C
- imgSize  in  SIZE_W  input side S
- windowSize  in  SIZE_W  window / stride k
- imgsAddress  in  ADDR_W  input base
- outAddress  in  ADDR_W  output base
- rdAddr  out  ADDR_W  read address
- rdEnable  out  1  read request
- rdData  in  DATA_W  read data, valid exactly 1 cycle after rdEnable
- wrAddr  out  ADDR_W  write address
- wrData  out  DATA_W  pooled result
- wrEnable  out  1  write strobe, one cycle per output
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- error  out  1  set with done when the job was rejected

All outputs reset to 0.

## Operation
- All job inputs are latched at start. Later changes are ignored until the next job.
- O = floor(S/k). Trailing rows and columns beyond O·k are never read.
- Rejected job: k ∉ {1, 2, 4}, k > MAX_WIN, C = 0, or S < k. Goes SETUP→DONE with error=1. No reads, no writes.
- Loop order: channel c (outer), oy, ox, then window row i, window column j (inner).
- Read address: imgsAddress + c·S² + (oy·k+i)·S + ox·k + j, modulo 2^ADDR_W.
- Write address: outAddress + c·O² + oy·O + ox, modulo 2^ADDR_W. Outputs are contiguous.
- Max mode: signed compare. Accumulator starts at the first element of the window.
- Average mode: signed sum in a DATA_W+4 bit accumulator, then arithmetic right shift by log2(k²), which floors toward −∞. The result is truncated to DATA_W; no overflow is possible.
- FSM states: IDLE, SETUP, READ, DRAIN, WRITE, DONE.
  - IDLE→SETUP on start.
  - SETUP→READ, or SETUP→DONE if rejected.
  - READ lasts k² cycles.
  - READ→DRAIN→WRITE.
  - WRITE→READ if outputs remain, else WRITE→DONE.
  - DONE→IDLE.
- start is ignored while busy. Asserting start during the DONE cycle is also ignored.
- reset at any point immediately clears all outputs and the FSM to IDLE. A partial job is abandoned; already-written words stay written.

## Timing
- Let start be sampled at edge E0. busy=1 from E0 until the edge that leaves DONE.
- SETUP occupies cycle E0–E1.
- Output p (0-based) has its first READ cycle at edge E(1 + p·(k²+2)).
- rdEnable is high for k² consecutive cycles. rdAddr changes every cycle.
- Accumulation takes rdData on the edge after each read.
- DRAIN captures the last element. WRITE drives wrEnable=1 with registered wrAddr/wrData for exactly one cycle.
- With P = C·O² outputs, done=1 in the cycle after edge E(1 + P·(k²+2)), lasting one cycle.
- A rejected job raises done/error in the cycle after E1.
- rdEnable and wrEnable are never high in the same cycle.

## Structure
- Package pool_pkg holds:
  - pool_mode_e (MAX, AVG)
  - pool_state_e (the six states)
  - default DATA_W / ADDR_W / SIZE_W localparams
  - a log2-of-window function shared with the conv layer
- Sub-module pool_window_acc holds the accumulator. Ports: clk, reset, clear, mode, shift, in_valid, in_data, result. It is the only arithmetic in the block.
- The top holds the FSM and the address counters (c, oy, ox, i, j), using incremental adds rather than multiplies in the loop.

## Test plan
- 1 channel, S=4, pixels 1..16 row-major at 0x0100, k=2, max, out 0x0200 -> writes 6, 8, 14, 16 at 0x0200..0x0203; done in the cycle after E25.
- Same image, average -> writes 3, 5, 11, 13; e.g. (1+2+5+6)=14, 14>>2 = 3.
- Window {−1, −2, −3, −4}, k=2 -> max −1; average −10>>2 = −3.
- C=2, S=5, k=2 -> 8 writes at out..out+7; row 4 / column 4 addresses never appear on rdAddr; channel 1 reads start at imgsAddress+25.
- k=3 (and separately C=0) -> done=1 and error=1 in the cycle after E1; rdEnable and wrEnable stay 0.
- reset pulsed mid-READ of output 2 -> all outputs 0 immediately, FSM in IDLE; a following start runs the full job correctly; start pulses while busy are ignored.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling layer: mode/state enums, default widths,
// and the window log2 used by both the pooling and conv layers.
package pool_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int SIZE_W_DEF = 8;

  typedef enum logic {
    MAX = 1'b0,
    AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    DRAIN,
    WRITE,
    DONE
  } pool_state_e;

  // Index of the highest set bit; exact log2 for the power-of-two windows we accept.
  function automatic logic [4:0] win_log2(input logic [31:0] k);
    logic [4:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (k[b]) r = 5'(b);
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_window_acc.sv
// Window accumulator: running signed max or signed sum, finalised to DATA_W after
// every accepted element so the result register holds the pooled word after the last one.
module pool_window_acc
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  pool_mode_e               mode,
  input  logic [4:0]               shift,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] result
);

  // Four guard bits hold the sum of up to 16 elements of a 4x4 window.
  localparam int ACC_W = DATA_W + 4;

  function automatic logic signed [ACC_W-1:0] max_sel(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Average divides by k*k with an arithmetic shift, flooring toward minus infinity.
  function automatic logic signed [DATA_W-1:0] finalize(input logic signed [ACC_W-1:0] acc,
                                                        input pool_mode_e m,
                                                        input logic [4:0] sh);
    logic signed [ACC_W-1:0] q;
    q = (m == AVG) ? (acc >>> sh) : acc;
    return q[DATA_W-1:0];
  endfunction

  logic                    first_q;
  logic signed [ACC_W-1:0] acc_p1;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] in_ext;

  assign in_ext = {{4{in_data[DATA_W-1]}}, in_data};

  always_comb begin
    acc_nxt = in_ext;
    if (!first_q) begin
      acc_nxt = (mode == MAX) ? max_sel(in_ext, acc_p1) : (acc_p1 + in_ext);
    end
  end

  // Stage p1: element captured one cycle after its read request.
  always_ff @(posedge clk) begin
    if (in_valid) acc_p1 <= acc_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q <= 1'b1;
      result  <= '0;
    end else if (clear) begin
      first_q <= 1'b1;
    end else if (in_valid) begin
      first_q <= 1'b0;
      result  <= finalize(acc_nxt, mode, shift);
    end
  end

endmodule

// File: rtl/pool_layer_param.sv
// Streaming k x k max/average pooling over C square feature maps in layer memory.
// FSM plus incrementally updated address pointers; all data arithmetic lives in pool_window_acc.
module pool_layer_param
  import pool_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int SIZE_W  = SIZE_W_DEF,
  parameter int MAX_WIN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [SIZE_W-1:0]        imgsNumber,
  input  logic [SIZE_W-1:0]        imgSize,
  input  logic [SIZE_W-1:0]        windowSize,
  input  logic [ADDR_W-1:0]        imgsAddress,
  input  logic [ADDR_W-1:0]        outAddress,
  output logic [ADDR_W-1:0]        rdAddr,
  output logic                     rdEnable,
  input  logic signed [DATA_W-1:0] rdData,
  output logic [ADDR_W-1:0]        wrAddr,
  output logic signed [DATA_W-1:0] wrData,
  output logic                     wrEnable,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  pool_state_e state_q, state_n;

  pool_mode_e        mode_q;
  logic [SIZE_W-1:0] c_num_q, s_q, k_q;
  logic [ADDR_W-1:0] in_base_q, out_base_q;
  logic              rej_q;

  logic [SIZE_W-1:0] c_cnt, oy, ox, wi, wj;
  logic [ADDR_W-1:0] ch_base, row_base, win_base, row_ptr, s_sq;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, nxt_win;
  logic              rd_vld_p1;

  logic [4:0]        lk, acc_shift;
  logic [SIZE_W-1:0] o_side, k_m1, o_m1, c_m1;
  logic [ADDR_W-1:0] s_ext, k_ext, ks_ext;
  logic              legal, win_last, out_last;

  assign lk        = win_log2(32'(k_q));
  assign acc_shift = lk << 1;
  assign o_side    = s_q >> lk;
  assign k_m1      = k_q - SIZE_W'(1);
  assign o_m1      = o_side - SIZE_W'(1);
  assign c_m1      = c_num_q - SIZE_W'(1);
  assign s_ext     = ADDR_W'(s_q);
  assign k_ext     = ADDR_W'(k_q);
  assign ks_ext    = s_ext << lk;

  assign legal = ((k_q == SIZE_W'(1)) || (k_q == SIZE_W'(2)) || (k_q == SIZE_W'(4)))
              && (k_q <= SIZE_W'(MAX_WIN)) && (c_num_q != '0) && (s_q >= k_q);

  assign win_last = (wi == k_m1) && (wj == k_m1);
  assign out_last = (c_cnt == c_m1) && (oy == o_m1) && (ox == o_m1);

  // Top-left address of the next window: step right, else down a block row, else next channel.
  always_comb begin
    nxt_win = ch_base + s_sq;
    if (ox != o_m1)      nxt_win = win_base + k_ext;
    else if (oy != o_m1) nxt_win = row_base + ks_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = SETUP;
      SETUP:   state_n = legal ? READ : DONE;
      READ:    if (win_last) state_n = DRAIN;
      DRAIN:   state_n = WRITE;
      WRITE:   state_n = out_last ? DONE : READ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      mode_q     <= pool_mode_e'(mode);
      c_num_q    <= imgsNumber;
      s_q        <= imgSize;
      k_q        <= windowSize;
      in_base_q  <= imgsAddress;
      out_base_q <= outAddress;
    end
  end

  // Loop counters and row/window/channel base pointers, advanced by adds only.
  always_ff @(posedge clk) begin
    case (state_q)
      SETUP: begin
        rej_q    <= !legal;
        c_cnt    <= '0;
        oy       <= '0;
        ox       <= '0;
        wi       <= '0;
        wj       <= '0;
        ch_base  <= in_base_q;
        row_base <= in_base_q;
        win_base <= in_base_q;
        row_ptr  <= in_base_q;
        s_sq     <= s_ext * s_ext;
      end
      READ: begin
        if (wj != k_m1) begin
          wj <= wj + SIZE_W'(1);
        end else begin
          wj <= '0;
          if (wi != k_m1) begin
            wi      <= wi + SIZE_W'(1);
            row_ptr <= row_ptr + s_ext;
          end
        end
      end
      WRITE: begin
        wi       <= '0;
        win_base <= nxt_win;
        row_ptr  <= nxt_win;
        if (ox != o_m1) begin
          ox <= ox + SIZE_W'(1);
        end else begin
          ox <= '0;
          row_base <= nxt_win;
          if (oy != o_m1) begin
            oy <= oy + SIZE_W'(1);
          end else begin
            oy      <= '0;
            c_cnt   <= c_cnt + SIZE_W'(1);
            ch_base <= nxt_win;
          end
        end
      end
      default: ;
    endcase
  end

  // Stage p0: read request address; stage p1 valid follows rdEnable by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= (state_q == READ);
      case (state_q)
        SETUP: begin
          rd_addr_q <= in_base_q;
          wr_addr_q <= out_base_q;
        end
        READ: begin
          if (wj != k_m1)      rd_addr_q <= rd_addr_q + ADDR_W'(1);
          else if (wi != k_m1) rd_addr_q <= row_ptr + s_ext;
        end
        WRITE: begin
          rd_addr_q <= nxt_win;
          wr_addr_q <= wr_addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  pool_window_acc #(
    .DATA_W(DATA_W)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state_q == SETUP) || (state_q == WRITE)),
    .mode    (mode_q),
    .shift   (acc_shift),
    .in_valid(rd_vld_p1),
    .in_data (rdData),
    .result  (wrData)
  );

  assign rdAddr   = rd_addr_q;
  assign rdEnable = (state_q == READ);
  assign wrAddr   = wr_addr_q;
  assign wrEnable = (state_q == WRITE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign error    = (state_q == DONE) && rej_q;

endmodule
